// File: rtl/vram_slot_ctrl.sv
// Time-slotted VRAM controller: PF, MO and alpha fetch slots plus one 68k slot.
// Define VRAM_BYTE_WRITE_EN to honour cpu_be on 68k writes; otherwise writes are full-word.
module vram_slot_ctrl #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 13,
    parameter int                COL_W   = 6,
    parameter int                VS_W    = 9,
    parameter logic [ADDR_W-1:0] PF_BASE = '0
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                slot_en,
    input  logic [COL_W-1:0]    pfh,
    input  logic [ADDR_W-1:0]   mo_addr,
    input  logic [ADDR_W-1:0]   al_addr,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic [DATA_W-1:0]   pf_data,
    output logic [DATA_W-1:0]   mo_data,
    output logic [DATA_W-1:0]   al_data,
    output logic                pf_vld,
    output logic                mo_vld,
    output logic                al_vld,
    input  logic                vscrl_ld,
    input  logic [VS_W-1:0]     vscrl_in,
    input  logic                line_stb,
    output logic [VS_W-1:0]     pfv,
    output logic [1:0]          slot
);

    // state  | meaning
    // S_PF   | slot 0, playfield fetch
    // S_MO   | slot 1, motion-object fetch
    // S_AL   | slot 2, alphanumerics fetch
    // S_CPU  | slot 3, 68k read/write
    typedef enum logic [1:0] {S_PF = 2'd0, S_MO = 2'd1, S_AL = 2'd2, S_CPU = 2'd3} slot_t;

    localparam int DEPTH = 2**ADDR_W;
    localparam int PFA_W = VS_W - 3 + COL_W;
    localparam int BE_W  = DATA_W / 8;

    slot_t               slot_q;
    logic [VS_W-1:0]     pfv_q, pfv_d;
    logic                pf_vld_q, mo_vld_q, al_vld_q, cpu_ack_q;
    logic [DATA_W-1:0]   pf_data_q, mo_data_q, al_data_q, cpu_rdata_q;
    logic [PFA_W-1:0]    pf_raw;
    logic [ADDR_W-1:0]   pf_addr, acc_addr;
    logic                cpu_go, cpu_wr;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Playfield row index uses the scroll position in 8-line tiles.
    assign pf_raw = {pfv_q[VS_W-1:3], pfh};

    generate
        if (PFA_W >= ADDR_W) begin : g_pf_trunc
            assign pf_addr = PF_BASE | pf_raw[ADDR_W-1:0];
        end else begin : g_pf_ext
            assign pf_addr = PF_BASE | {{(ADDR_W-PFA_W){1'b0}}, pf_raw};
        end
    endgenerate

    always_comb begin
        acc_addr = cpu_addr;
        case (slot_q)
            S_PF:    acc_addr = pf_addr;
            S_MO:    acc_addr = mo_addr;
            S_AL:    acc_addr = al_addr;
            default: acc_addr = cpu_addr;
        endcase
    end

    assign cpu_go  = slot_en & (slot_q == S_CPU) & cpu_req;
    assign cpu_wr  = cpu_go & cpu_we;
    assign rd_word = mem[acc_addr];

`ifdef VRAM_BYTE_WRITE_EN
    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (cpu_be[i]) begin
                    mem[cpu_addr][8*i +: 8] <= cpu_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    logic unused_be;
    assign unused_be = ^cpu_be;

    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            mem[cpu_addr] <= cpu_wdata;
        end
    end
`endif

    always_comb begin
        pfv_d = pfv_q;
        if (vscrl_ld) begin
            pfv_d = vscrl_in;
        end else if (line_stb) begin
            pfv_d = pfv_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            slot_q      <= S_PF;
            pfv_q       <= '0;
            pf_vld_q    <= 1'b0;
            mo_vld_q    <= 1'b0;
            al_vld_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pf_data_q   <= '0;
            mo_data_q   <= '0;
            al_data_q   <= '0;
            cpu_rdata_q <= '0;
        end else begin
            pfv_q     <= pfv_d;
            pf_vld_q  <= slot_en && (slot_q == S_PF);
            mo_vld_q  <= slot_en && (slot_q == S_MO);
            al_vld_q  <= slot_en && (slot_q == S_AL);
            cpu_ack_q <= cpu_go;
            if (slot_en) begin
                case (slot_q)
                    S_PF: begin
                        pf_data_q <= rd_word;
                        slot_q    <= S_MO;
                    end
                    S_MO: begin
                        mo_data_q <= rd_word;
                        slot_q    <= S_AL;
                    end
                    S_AL: begin
                        al_data_q <= rd_word;
                        slot_q    <= S_CPU;
                    end
                    default: begin
                        if (cpu_req && !cpu_we) begin
                            cpu_rdata_q <= rd_word;
                        end
                        slot_q <= S_PF;
                    end
                endcase
            end
        end
    end

    assign slot      = slot_q;
    assign pfv       = pfv_q;
    assign pf_vld    = pf_vld_q;
    assign mo_vld    = mo_vld_q;
    assign al_vld    = al_vld_q;
    assign cpu_ack   = cpu_ack_q;
    assign pf_data   = pf_data_q;
    assign mo_data   = mo_data_q;
    assign al_data   = al_data_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vram_slot_ctrl.sv
// Directed bench for vram_slot_ctrl: slot sequencing, CPU handshake, fetch paths,
// scroll counter table, stall/abort/reset corners and byte-lane writes.
module tb_vram_slot_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int COL_W  = 6;
    localparam int VS_W   = 9;

    logic                clk = 1'b0;
    logic                rst_b = 1'b0;
    logic                slot_en = 1'b0;
    logic [COL_W-1:0]    pfh = '0;
    logic [ADDR_W-1:0]   mo_addr = '0;
    logic [ADDR_W-1:0]   al_addr = '0;
    logic                cpu_req = 1'b0;
    logic                cpu_we = 1'b0;
    logic [ADDR_W-1:0]   cpu_addr = '0;
    logic [DATA_W-1:0]   cpu_wdata = '0;
    logic [DATA_W/8-1:0] cpu_be = '0;
    logic                cpu_ack;
    logic [DATA_W-1:0]   cpu_rdata;
    logic [DATA_W-1:0]   pf_data, mo_data, al_data;
    logic                pf_vld, mo_vld, al_vld;
    logic                vscrl_ld = 1'b0;
    logic [VS_W-1:0]     vscrl_in = '0;
    logic                line_stb = 1'b0;
    logic [VS_W-1:0]     pfv;
    logic [1:0]          slot;

    int checks = 0;
    int errors = 0;
    int m_slot = 0;

    typedef struct {
        logic            ld;
        logic            stb;
        logic [VS_W-1:0] vin;
        logic [VS_W-1:0] exp_pfv;
    } scr_vec_t;

    scr_vec_t sv [9];

    vram_slot_ctrl dut (
        .clk(clk), .rst_b(rst_b), .slot_en(slot_en), .pfh(pfh),
        .mo_addr(mo_addr), .al_addr(al_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .pf_data(pf_data), .mo_data(mo_data), .al_data(al_data),
        .pf_vld(pf_vld), .mo_vld(mo_vld), .al_vld(al_vld),
        .vscrl_ld(vscrl_ld), .vscrl_in(vscrl_in), .line_stb(line_stb),
        .pfv(pfv), .slot(slot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock; expected strobes follow from the bench's own slot model.
    task automatic step();
        logic e_pf, e_mo, e_al, e_ack;
        e_pf  = slot_en && (m_slot == 0);
        e_mo  = slot_en && (m_slot == 1);
        e_al  = slot_en && (m_slot == 2);
        e_ack = slot_en && (m_slot == 3) && cpu_req;
        @(posedge clk);
        #1;
        if (slot_en) m_slot = (m_slot + 1) % 4;
        chk("slot", {30'd0, slot}, m_slot);
        chk("pf_vld", pf_vld, e_pf);
        chk("mo_vld", mo_vld, e_mo);
        chk("al_vld", al_vld, e_al);
        chk("cpu_ack", cpu_ack, e_ack);
    endtask

    task automatic check_reset_state();
        chk("rst_slot", {30'd0, slot}, 0);
        chk("rst_pfv", pfv, 0);
        chk("rst_pf_vld", pf_vld, 0);
        chk("rst_mo_vld", mo_vld, 0);
        chk("rst_al_vld", al_vld, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_pf_data", pf_data, 0);
        chk("rst_mo_data", mo_data, 0);
        chk("rst_al_data", al_data, 0);
        chk("rst_rdata", cpu_rdata, 0);
    endtask

    task automatic xfer(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic [1:0] be, output logic [DATA_W-1:0] rd);
        bit got;
        got = 0;
        rd = '0;
        slot_en = 1'b1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            if (cpu_ack === 1'b1) begin
                got = 1;
                rd = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        chk("xfer_ack_seen", {31'd0, got}, 1);
    endtask

    task automatic fetch_wait(input int which, output logic [DATA_W-1:0] d);
        bit got;
        got = 0;
        d = '0;
        slot_en = 1'b1;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            case (which)
                0: if (pf_vld === 1'b1) begin got = 1; d = pf_data; end
                1: if (mo_vld === 1'b1) begin got = 1; d = mo_data; end
                default: if (al_vld === 1'b1) begin got = 1; d = al_data; end
            endcase
        end
        chk("fetch_seen", {31'd0, got}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] exp_bw;

        sv[0] = '{1'b1, 1'b0, 9'h1FF, 9'h1FF};
        sv[1] = '{1'b0, 1'b1, 9'h000, 9'h000};
        sv[2] = '{1'b0, 1'b1, 9'h000, 9'h001};
        sv[3] = '{1'b1, 1'b1, 9'h010, 9'h010};
        sv[4] = '{1'b0, 1'b0, 9'h0F0, 9'h010};
        sv[5] = '{1'b0, 1'b1, 9'h000, 9'h011};
        sv[6] = '{1'b1, 1'b0, 9'h0AB, 9'h0AB};
        sv[7] = '{1'b1, 1'b1, 9'h1FF, 9'h1FF};
        sv[8] = '{1'b0, 1'b1, 9'h000, 9'h000};

        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_b = 1'b1;
        m_slot = 0;

        // idle rotation, no CPU traffic
        slot_en = 1'b1;
        repeat (9) step();

        xfer(1'b1, 13'h0123, 16'hBEEF, 2'b11, rd);
        xfer(1'b0, 13'h0123, 16'h0000, 2'b11, rd);
        chk("cpu_read_beef", rd, 16'hBEEF);

        xfer(1'b1, 13'h1005, 16'h1234, 2'b11, rd);
        mo_addr = 13'h1005;
        fetch_wait(1, rd);
        chk("mo_fetch", rd, 16'h1234);
        xfer(1'b1, 13'h1005, 16'h5A5A, 2'b11, rd);
        fetch_wait(1, rd);
        chk("mo_after_write", rd, 16'h5A5A);

        xfer(1'b1, 13'h0077, 16'h0F0F, 2'b11, rd);
        al_addr = 13'h0077;
        fetch_wait(2, rd);
        chk("al_fetch", rd, 16'h0F0F);

        // scroll counter vectors, sequencer frozen
        slot_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vscrl_ld = sv[i].ld;
            line_stb = sv[i].stb;
            vscrl_in = sv[i].vin;
            step();
            chk($sformatf("pfv_vec%0d", i), pfv, sv[i].exp_pfv);
        end
        vscrl_ld = 1'b0;
        line_stb = 1'b0;

        vscrl_ld = 1'b1;
        vscrl_in = 9'h010;
        step();
        vscrl_ld = 1'b0;
        chk("pfv_loaded", pfv, 9'h010);
        pfh = 6'h05;
        xfer(1'b1, 13'h0085, 16'hCAFE, 2'b11, rd);
        fetch_wait(0, rd);
        chk("pf_fetch_0085", rd, 16'hCAFE);
        pfh = 6'h3F;
        xfer(1'b1, 13'h00BF, 16'hD00D, 2'b11, rd);
        fetch_wait(0, rd);
        chk("pf_fetch_00bf", rd, 16'hD00D);

        // stall with a pending read
        slot_en = 1'b1;
        for (int i = 0; i < 6 && m_slot != 2; i++) step();
        slot_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
        repeat (10) step();
        slot_en = 1'b1;
        step();
        step();
        chk("stall_then_ack", cpu_ack, 1);
        chk("stall_read", cpu_rdata, 16'hBEEF);
        cpu_req = 1'b0;

        // request withdrawn before slot 3
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 16'hDEAD; cpu_be = 2'b11;
        step();
        step();
        cpu_req = 1'b0;
        step();
        step();
        xfer(1'b0, 13'h0123, 16'h0000, 2'b11, rd);
        chk("no_write_on_drop", rd, 16'hBEEF);

        // reset asserted on the ack cycle
        for (int i = 0; i < 6 && m_slot != 0; i++) step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0077;
        repeat (4) step();
        rst_b = 1'b0;
        cpu_req = 1'b0;
        m_slot = 0;
        #1;
        chk("abort_ack", cpu_ack, 0);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (8) step();

        xfer(1'b1, 13'h0200, 16'hAAAA, 2'b11, rd);
        xfer(1'b1, 13'h0200, 16'h5555, 2'b01, rd);
        xfer(1'b0, 13'h0200, 16'h0000, 2'b11, rd);
`ifdef VRAM_BYTE_WRITE_EN
        exp_bw = 16'hAA55;
`else
        exp_bw = 16'h5555;
`endif
        chk("byte_write_lo", rd, exp_bw);
        xfer(1'b1, 13'h0200, 16'h1111, 2'b00, rd);
        xfer(1'b0, 13'h0200, 16'h0000, 2'b11, rd);
`ifdef VRAM_BYTE_WRITE_EN
        exp_bw = 16'hAA55;
`else
        exp_bw = 16'h1111;
`endif
        chk("byte_write_none", rd, exp_bw);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_slot_ctrl.md
# vram_slot_ctrl

Parametrised, time-slotted video RAM controller that owns the playfield/motion-object/alphanumerics word store and arbitrates it between three fixed video fetch slots and one 68k access slot. It succeeds the fixed-width VRAM block: it adds a parametrised address and data width, a 68k request/acknowledge handshake, registered per-client fetch outputs with valid strobes, and a wrapping playfield vertical-scroll counter with its own load. It sits between the address decoder / 68k bus interface and the playfield, MO and alpha pipelines, and is driven by the clock-gen slot enable.

## Interface
Parameters:
- DATA_W, 16, VRAM word width
- ADDR_W, 13, word address width (store depth 2**ADDR_W)
- COL_W, 6, playfield column (PFH) width
- VS_W, 9, vertical-scroll counter width (must be > 3)
- PF_BASE, 13'h0000, playfield region base (OR'ed into the address)

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- slot_en  in  1  advance slot sequencer (from clock gen)
- pfh  in  COL_W  playfield column for slot 0
- mo_addr  in  ADDR_W  MO fetch address for slot 1
- al_addr  in  ADDR_W  alpha fetch address for slot 2
- cpu_req  in  1  68k access request, held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  68k word address
- cpu_wdata  in  DATA_W  write data
- cpu_be  in  DATA_W/8  byte enables (used only with VRAM_BYTE_WRITE_EN)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack
- pf_data / mo_data / al_data  out  DATA_W  fetched words
- pf_vld / mo_vld / al_vld  out  1  one-cycle valid strobes
- vscrl_ld  in  1  load scroll counter
- vscrl_in  in  VS_W  scroll load value
- line_stb  in  1  one-cycle end-of-active-line pulse (HSYNC & VBLANK_b, edge-qualified upstream)
- pfv  out  VS_W  current playfield vertical position
- slot  out  2  current slot number

## Operation
- Slot counter: 2 bits, increments modulo 4 on clk when slot_en = 1; it holds when slot_en = 0. Slot 0 = PF, 1 = MO, 2 = alpha, 3 = CPU.
- The store is a single-port, synchronous-read RAM of 2**ADDR_W x DATA_W. It is accessed only on a cycle with slot_en = 1, at the address selected by the current slot.
- Slot 0 address = PF_BASE | zero-extended {pfv[VS_W-1:3], pfh}. Excess high bits are truncated to ADDR_W.
- Slot 1 address = mo_addr. Slot 2 address = al_addr.
- Slot 3: if cpu_req = 1, the store is accessed at cpu_addr. A write stores cpu_wdata. A read captures the word into cpu_rdata. If cpu_req = 0, the store is idle.
- cpu_req low at the slot-3 cycle means no access and no ack. cpu_addr, cpu_we, cpu_wdata and cpu_be are sampled only at the slot-3 cycle. The requester deasserts cpu_req on the ack cycle. If cpu_req is still high at the next slot 3, a new access is performed.
- Video reads in slots 0 to 2 never write the store.
- Scroll counter pfv:
  - vscrl_ld = 1 loads vscrl_in.
  - Otherwise, line_stb = 1 increments pfv modulo 2**VS_W, so the maximum value wraps to 0.
  - When vscrl_ld and line_stb are asserted together, the load wins.
  - pfv updates independently of slot_en.

## Timing
- Reset values: slot = 0, pfv = 0, all *_vld = 0, cpu_ack = 0, all data outputs = 0. RAM contents are not reset.
- Fetch latency is 1 cycle. The strobe x_vld pulses on the cycle after the slot-N access cycle, with x_data valid on that same cycle. x_data holds its value until the next fetch for that client.
- CPU latency: cpu_ack pulses for exactly one cycle, on the cycle after the slot-3 access, for both reads and writes. cpu_rdata is valid on that cycle and holds until the next read. Worst-case wait from req to ack is 5 slot_en cycles.
- A write followed by a same-address fetch in the next slot returns the new data (write-first).
- A pfv change is visible to the slot-0 address on the cycle after the load or increment.
- Reset asserted mid-access: an in-flight ack or valid is cancelled and the pending request is dropped. After release the sequencer restarts at slot 0.

## Configuration
- VRAM_BYTE_WRITE_EN defined:
  - A slot-3 write updates only the byte lanes whose cpu_be bit is 1.
  - cpu_be = 0 still acks but leaves the store unchanged.
- VRAM_BYTE_WRITE_EN undefined:
  - cpu_be is ignored and every write updates the full word.

## Test plan
- Reset and idle: hold rst_b low, release with slot_en = 1 -> slot cycles 0,1,2,3,0. pfv = 0. pf_vld, mo_vld and al_vld each pulse once per 4 cycles. cpu_ack stays 0.
- CPU write then read: write 16'hBEEF to address 13'h0123, then read the same address -> each transaction acks exactly once, one cycle after its slot 3, and the read returns 16'hBEEF.
- Fetch path: preload 16'h1234 at 13'h1005 and set mo_addr = 13'h1005 -> mo_vld is asserted with mo_data = 16'h1234.
- Scroll wrap and priority:
  - Load 9'h1FF, then pulse line_stb -> pfv = 0.
  - Assert vscrl_ld = 1 (vscrl_in = 9'h010) together with line_stb -> pfv = 9'h010.
  - With pfv = 9'h010 and pfh = 6'h05, the slot-0 address is 13'h0085.
- Stall and abort:
  - Set slot_en = 0 for 10 cycles with cpu_req high -> no ack, slot frozen.
  - Drop cpu_req before slot 3 -> no access.
  - Assert rst_b low on the ack cycle -> no ack.
- Byte write (VRAM_BYTE_WRITE_EN): word = 16'hAAAA, write 16'h5555 with cpu_be = 2'b01 -> read back 16'hAA55. Macro undefined -> read back 16'h5555.
